// File: rtl/hsv_stream_tx.sv
`default_nettype none
// ============================================================================
// Module   : hsv_stream_tx
// Purpose  : Serialises 24-bit HSV pixels LSB first as a tx_clk/tx_data pair,
//            one frame of FRAME_PIXELS pixels per start request.
// Revision : 1.0 - initial release
// ============================================================================
module hsv_stream_tx #(
    parameter int LENGTH       = 16,
    parameter int WIDTH        = 16,
    parameter int HALF_PERIOD  = 4000,
    parameter int FRAME_PIXELS = LENGTH * WIDTH
) (
    input  logic        fpga_clk,
    input  logic        rst,
    input  logic        start,
    input  logic        pix_valid,
    input  logic [23:0] pix_data,
    output logic        pix_ready,
    output logic        tx_clk,
    output logic        tx_data,
    output logic        busy,
    output logic        frame_done,
    output logic [15:0] pix_count
);

    localparam int                 c_CNT_W        = $clog2(HALF_PERIOD + 1);
    localparam logic [c_CNT_W-1:0] c_HALF_LAST    = c_CNT_W'(HALF_PERIOD - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE      = c_CNT_W'(1);
    localparam logic [15:0]        c_FRAME_PIXELS = 16'(FRAME_PIXELS);
    localparam logic [4:0]         c_LAST_BIT     = 5'd23;

    localparam logic [2:0] c_S_IDLE     = 3'd0;
    localparam logic [2:0] c_S_WAIT_PIX = 3'd1;
    localparam logic [2:0] c_S_LOW      = 3'd2;
    localparam logic [2:0] c_S_HIGH     = 3'd3;
    localparam logic [2:0] c_S_DONE     = 3'd4;

    logic [2:0]         r_state;
    logic [23:0]        r_shreg;
    logic [4:0]         r_bit_idx;
    logic [c_CNT_W-1:0] r_half_cnt;
    logic [15:0]        r_pix_count;

    logic               w_half_end;
    logic [15:0]        w_pix_count_nxt;

    assign w_half_end      = (r_half_cnt == c_HALF_LAST);
    assign w_pix_count_nxt = r_pix_count + 16'd1;

    always_ff @(posedge fpga_clk) begin
        if (rst) begin
            r_state     <= c_S_IDLE;
            r_shreg     <= 24'd0;
            r_bit_idx   <= 5'd0;
            r_half_cnt  <= '0;
            r_pix_count <= 16'd0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (start) begin
                        r_pix_count <= 16'd0;
                        r_state     <= c_S_WAIT_PIX;
                    end
                end
                c_S_WAIT_PIX: begin
                    if (pix_valid) begin
                        r_shreg    <= pix_data;
                        r_bit_idx  <= 5'd0;
                        r_half_cnt <= '0;
                        r_state    <= c_S_LOW;
                    end
                end
                c_S_LOW: begin
                    if (w_half_end) begin
                        r_half_cnt <= '0;
                        r_state    <= c_S_HIGH;
                    end else begin
                        r_half_cnt <= r_half_cnt + c_CNT_ONE;
                    end
                end
                c_S_HIGH: begin
                    if (w_half_end) begin
                        r_half_cnt <= '0;
                        // Data only advances on the falling edge, keeping it stable while tx_clk is high
                        if (r_bit_idx == c_LAST_BIT) begin
                            r_pix_count <= w_pix_count_nxt;
                            r_state     <= (w_pix_count_nxt == c_FRAME_PIXELS) ? c_S_DONE : c_S_WAIT_PIX;
                        end else begin
                            r_bit_idx <= r_bit_idx + 5'd1;
                            r_state   <= c_S_LOW;
                        end
                    end else begin
                        r_half_cnt <= r_half_cnt + c_CNT_ONE;
                    end
                end
                c_S_DONE: begin
                    r_state <= c_S_IDLE;
                end
                default: begin
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

    assign pix_ready  = (r_state == c_S_WAIT_PIX);
    assign tx_clk     = (r_state == c_S_HIGH);
    assign busy       = (r_state != c_S_IDLE);
    assign frame_done = (r_state == c_S_DONE);
    assign tx_data    = r_shreg[r_bit_idx];
    assign pix_count  = r_pix_count;

endmodule
`default_nettype wire

// File: tb/tb_hsv_stream_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_hsv_stream_tx
// Purpose  : Self-checking bench for hsv_stream_tx with a loopback receiver
//            and a pixel scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hsv_stream_tx;

    localparam int c_HP = 3;
    localparam int c_FP = 2;

    logic        fpga_clk  = 1'b0;
    logic        rst       = 1'b1;
    logic        start     = 1'b0;
    logic        pix_valid = 1'b0;
    logic [23:0] pix_data  = 24'd0;
    logic        pix_ready;
    logic        tx_clk;
    logic        tx_data;
    logic        busy;
    logic        frame_done;
    logic [15:0] pix_count;

    int          n_checks    = 0;
    int          n_fail      = 0;
    int          cyc         = 0;
    int          accept_cyc  = 0;
    int          rises       = 0;
    int          done_pulses = 0;
    int          rx_nbits    = 0;
    logic [23:0] rx_word;
    logic [23:0] sb_q[$];

    hsv_stream_tx #(
        .HALF_PERIOD  (c_HP),
        .FRAME_PIXELS (c_FP)
    ) dut (
        .fpga_clk   (fpga_clk),
        .rst        (rst),
        .start      (start),
        .pix_valid  (pix_valid),
        .pix_data   (pix_data),
        .pix_ready  (pix_ready),
        .tx_clk     (tx_clk),
        .tx_data    (tx_data),
        .busy       (busy),
        .frame_done (frame_done),
        .pix_count  (pix_count)
    );

    always #5 fpga_clk = ~fpga_clk;
    always @(posedge fpga_clk) cyc <= cyc + 1;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge fpga_clk);
        start = 1'b1;
        @(negedge fpga_clk);
        start = 1'b0;
    endtask

    // Presents a pixel and returns just after the edge that accepts it.
    task automatic send_pixel(input logic [23:0] p);
        int n;
        n = 0;
        @(negedge fpga_clk);
        pix_valid = 1'b1;
        pix_data  = p;
        while (!pix_ready && n < 2000) begin
            @(negedge fpga_clk);
            n++;
        end
        chk_eq("send_ready", 32'(pix_ready), 32'd1);
        @(posedge fpga_clk);
        #1;
        accept_cyc = cyc;
        sb_q.push_back(p);
    endtask

    task automatic wait_frame_done();
        int n;
        n = 0;
        while (!frame_done && n < 2000) begin
            @(negedge fpga_clk);
            n++;
        end
        chk_eq("frame_done_seen", 32'(frame_done), 32'd1);
    endtask

    // Loopback receiver: samples tx_data on each tx_clk rise and checks phase timing.
    initial begin : monitor
        logic        prev_clk;
        logic        prev_data;
        int          run;
        logic [23:0] exp_pix;
        prev_clk  = 1'b0;
        prev_data = 1'b0;
        run       = 0;
        forever begin
            @(posedge fpga_clk);
            #1;
            if (rst) begin
                rx_nbits  = 0;
                run       = 0;
                prev_clk  = 1'b0;
                prev_data = 1'b0;
                sb_q.delete();
            end else begin
                if (tx_clk) chk_eq("data_hold_hi", 32'(tx_data), 32'(prev_data));
                if (tx_clk && !prev_clk) begin
                    rises++;
                    if (rx_nbits == 0) chk_eq("first_rise_lat", 32'(cyc - accept_cyc), 32'(c_HP));
                    else               chk_eq("low_phase", 32'(run), 32'(c_HP));
                    rx_word[rx_nbits] = tx_data;
                    rx_nbits++;
                    run = 1;
                    if (rx_nbits == 24) begin
                        chk_eq("sb_depth", 32'(sb_q.size() != 0), 32'd1);
                        if (sb_q.size() != 0) begin
                            exp_pix = sb_q.pop_front();
                            chk_eq("pixel", 32'(rx_word), 32'(exp_pix));
                        end
                        rx_nbits = 0;
                    end
                end else if (!tx_clk && prev_clk) begin
                    chk_eq("high_phase", 32'(run), 32'(c_HP));
                    run = 1;
                end else begin
                    run++;
                end
                if (frame_done) done_pulses++;
                prev_clk  = tx_clk;
                prev_data = tx_data;
            end
        end
    end

    initial begin : stim
        int          hi_in_gap;
        int          rises_mark;
        int          t_first;
        int          n;
        logic [23:0] p3;
        logic [23:0] p4;

        repeat (3) @(negedge fpga_clk);
        chk_eq("rst_tx_clk",     32'(tx_clk),     32'd0);
        chk_eq("rst_tx_data",    32'(tx_data),    32'd0);
        chk_eq("rst_busy",       32'(busy),       32'd0);
        chk_eq("rst_pix_ready",  32'(pix_ready),  32'd0);
        chk_eq("rst_frame_done", 32'(frame_done), 32'd0);
        chk_eq("rst_pix_count",  32'(pix_count),  32'd0);
        rst = 1'b0;
        repeat (3) @(negedge fpga_clk);
        chk_eq("idle_busy", 32'(busy), 32'd0);

        // start and pix_valid together: only start is taken
        start     = 1'b1;
        pix_valid = 1'b1;
        pix_data  = 24'hA5C30F;
        @(negedge fpga_clk);
        start     = 1'b0;
        pix_valid = 1'b0;
        chk_eq("start_only_wait", 32'(pix_ready), 32'd1);
        chk_eq("start_busy",      32'(busy),      32'd1);

        send_pixel(24'hA5C30F);
        pix_valid = 1'b0;
        pulse_start();
        n = 0;
        while (!pix_ready && n < 500) begin
            @(negedge fpga_clk);
            n++;
        end
        chk_eq("pix1_done_ready", 32'(pix_ready), 32'd1);
        chk_eq("pix_count_1",     32'(pix_count), 32'd1);
        chk_eq("rises_pix1",      32'(rises),     32'd24);

        // stall between pixels
        hi_in_gap = 0;
        repeat (50) begin
            @(negedge fpga_clk);
            if (tx_clk) hi_in_gap++;
        end
        chk_eq("gap_tx_clk_high", 32'(hi_in_gap), 32'd0);
        chk_eq("gap_busy",        32'(busy),      32'd1);
        chk_eq("gap_rises",       32'(rises),     32'd24);

        send_pixel(24'h3C5A96);
        pix_valid = 1'b0;
        wait_frame_done();
        chk_eq("frame1_count", 32'(pix_count), 32'd2);
        chk_eq("frame1_rises", 32'(rises),     32'd48);
        @(negedge fpga_clk);
        chk_eq("frame1_idle",  32'(busy),        32'd0);
        chk_eq("done_pulses",  32'(done_pulses), 32'd1);
        repeat (5) @(negedge fpga_clk);
        chk_eq("idle_keeps_count", 32'(pix_count), 32'd2);

        // reset in the high phase of bit 5
        pulse_start();
        send_pixel(24'h123456);
        pix_valid = 1'b0;
        n = 0;
        while (rx_nbits < 6 && n < 500) begin
            @(negedge fpga_clk);
            n++;
        end
        chk_eq("reach_bit5", 32'(rx_nbits), 32'd6);
        rst        = 1'b1;
        rises_mark = rises;
        @(negedge fpga_clk);
        chk_eq("midrst_tx_clk",    32'(tx_clk),    32'd0);
        chk_eq("midrst_busy",      32'(busy),      32'd0);
        chk_eq("midrst_pix_count", 32'(pix_count), 32'd0);
        chk_eq("midrst_tx_data",   32'(tx_data),   32'd0);
        rst = 1'b0;
        repeat (40) @(negedge fpga_clk);
        chk_eq("post_rst_rises", 32'(rises),     32'(rises_mark));
        chk_eq("post_rst_busy",  32'(busy),      32'd0);
        chk_eq("post_rst_ready", 32'(pix_ready), 32'd0);

        // back-to-back pixels
        p3 = 24'($urandom);
        p4 = 24'($urandom);
        pulse_start();
        send_pixel(p3);
        t_first = accept_cyc;
        send_pixel(p4);
        chk_eq("pixel_period", 32'(accept_cyc - t_first), 32'(48 * c_HP + 1));
        pix_valid = 1'b0;
        wait_frame_done();
        chk_eq("frame2_count", 32'(pix_count),          32'd2);
        chk_eq("frame2_rises", 32'(rises - rises_mark), 32'd48);
        repeat (5) @(negedge fpga_clk);
        chk_eq("sb_empty", 32'(sb_q.size()), 32'd0);
        chk_eq("done_pulses_total", 32'(done_pulses), 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
